sb_param_chain: RTL and testbench

Parametrised four-sided routing switch block with a shadowed configuration chain, the successor to the fixed-width generated switch blocks.
- Every output track on each side is a 4:1 select: off, or the same-index track from one of the other three sides.
- Configuration shifts in serially on the programming chain, but takes effect only on an explicit, length-checked commit, so routing never glitches while the chain is being loaded.
- Sits between CLB/connection-block tiles in the fabric array and daisy-chains with neighbouring blocks via `ccff_head`/`ccff_tail`.

---
 rtl/sb_param_chain_if.sv | 35 +++
 rtl/sb_param_chain.sv | 117 +++++++++++
 tb/tb_sb_param_chain.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_param_chain_if.sv
// Switch-block port bundle: configuration chain, status flags and the four
// track groups. The switch block takes the slave side; whoever drives the
// block (a tile wrapper or a bench) takes the master side.
interface sb_param_chain_if #(
    parameter int CHAN_WIDTH = 4
);
    logic                  ccff_head;
    logic                  ccff_en;
    logic                  ccff_commit;
    logic                  ccff_tail;
    logic                  cfg_valid;
    logic                  cfg_err;
    logic [0:CHAN_WIDTH-1] chany_top_in;
    logic [0:CHAN_WIDTH-1] chanx_right_in;
    logic [0:CHAN_WIDTH-1] chany_bottom_in;
    logic [0:CHAN_WIDTH-1] chanx_left_in;
    logic [0:CHAN_WIDTH-1] chany_top_out;
    logic [0:CHAN_WIDTH-1] chanx_right_out;
    logic [0:CHAN_WIDTH-1] chany_bottom_out;
    logic [0:CHAN_WIDTH-1] chanx_left_out;

    modport master (
        output ccff_head, ccff_en, ccff_commit,
        output chany_top_in, chanx_right_in, chany_bottom_in, chanx_left_in,
        input  ccff_tail, cfg_valid, cfg_err,
        input  chany_top_out, chanx_right_out, chany_bottom_out, chanx_left_out
    );

    modport slave (
        input  ccff_head, ccff_en, ccff_commit,
        input  chany_top_in, chanx_right_in, chany_bottom_in, chanx_left_in,
        output ccff_tail, cfg_valid, cfg_err,
        output chany_top_out, chanx_right_out, chany_bottom_out, chanx_left_out
    );
endinterface

// File: rtl/sb_param_chain.sv
// Four-sided routing switch block with a shadowed configuration chain.
// Bits shift into a shadow register; only a commit that arrives after
// exactly CFG_BITS shifted bits copies the shadow into the active routing
// configuration, so the tracks never glitch while the chain is loading.
// Each output track is a 4:1 select (off / same-index track from one of
// the other three sides, counted clockwise from the output side).
// Build option: define SB_OUT_REG_EN to register every *_out bit on
// prog_clk (one extra cycle of latency); otherwise the outputs are purely
// combinational from the active configuration and the inputs.
module sb_param_chain #(
    parameter int CHAN_WIDTH = 4
) (
    input  logic           prog_clk,
    input  logic           prog_reset,
    sb_param_chain_if.slave sb
);
    localparam int CFG_BITS = 8 * CHAN_WIDTH;
    localparam int CNT_W    = $clog2(CFG_BITS + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

    logic [0:CFG_BITS-1]   r_sr;
    logic [0:CFG_BITS-1]   r_act;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_valid;
    logic                  r_err;
    logic                  w_commit_ok;
    logic [0:CHAN_WIDTH-1] w_in  [0:3];
    logic [0:CHAN_WIDTH-1] w_mux [0:3];
    logic [0:CHAN_WIDTH-1] w_out [0:3];

    // A commit is good only when exactly one full chain length has been shifted.
    assign w_commit_ok = sb.ccff_commit && (r_cnt == CNT_FULL);

    // Serial shadow chain: new bit enters at index 0, tail leaves at the far end.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_sr <= '0;
        end else if (sb.ccff_en) begin
            r_sr <= {sb.ccff_head, r_sr[0:CFG_BITS-2]};
        end
    end

    // Shift counter: saturates one past full so over-length loads stay rejected.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_cnt <= '0;
        end else if (sb.ccff_commit) begin
            r_cnt <= sb.ccff_en ? CNT_W'(1) : '0;
        end else if (sb.ccff_en && (r_cnt != CNT_SAT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Active configuration and status flags; the error flag is sticky until reset.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_act   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_commit_ok) begin
                r_act   <= r_sr;
                r_valid <= 1'b1;
            end
            if (sb.ccff_commit && !w_commit_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    // Side order top, right, bottom, left is also clockwise order.
    assign w_in[0] = sb.chany_top_in;
    assign w_in[1] = sb.chanx_right_in;
    assign w_in[2] = sb.chany_bottom_in;
    assign w_in[3] = sb.chanx_left_in;

    // Per-track 4:1 select; select code n picks the n-th side clockwise.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            w_mux[s] = '0;
            for (int i = 0; i < CHAN_WIDTH; i++) begin
                case ({r_act[2*(s*CHAN_WIDTH+i)], r_act[2*(s*CHAN_WIDTH+i)+1]})
                    2'b01:   w_mux[s][i] = w_in[(s+1)%4][i];
                    2'b10:   w_mux[s][i] = w_in[(s+2)%4][i];
                    2'b11:   w_mux[s][i] = w_in[(s+3)%4][i];
                    default: w_mux[s][i] = 1'b0;
                endcase
            end
        end
    end

`ifdef SB_OUT_REG_EN
    logic [0:CHAN_WIDTH-1] r_out [0:3];

    // Registered track outputs, cleared with the configuration.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_out <= '{default: '0};
        end else begin
            r_out <= w_mux;
        end
    end

    assign w_out = r_out;
`else
    assign w_out = w_mux;
`endif

    assign sb.chany_top_out    = w_out[0];
    assign sb.chanx_right_out  = w_out[1];
    assign sb.chany_bottom_out = w_out[2];
    assign sb.chanx_left_out   = w_out[3];
    assign sb.ccff_tail        = r_sr[CFG_BITS-1];
    assign sb.cfg_valid        = r_valid;
    assign sb.cfg_err          = r_err;
endmodule

// File: tb/tb_sb_param_chain.sv
// Scoreboard bench for sb_param_chain. A driver applies one stimulus cycle
// at a time, advances a behavioural model (history of shifted bits, shift
// count since last commit, active select table) and pushes the expected
// post-edge response; a monitor pops and compares on every falling edge.
module tb_sb_param_chain;
    localparam int W  = 4;
    localparam int CB = 8 * W;

    typedef struct packed {
        logic [0:4*W-1] o;
        logic           tail;
        logic           valid;
        logic           err;
    } exp_t;

    logic prog_clk   = 1'b0;
    logic prog_reset = 1'b1;

    sb_param_chain_if #(.CHAN_WIDTH(W)) sb ();

    sb_param_chain #(.CHAN_WIDTH(W)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .sb         (sb.slave)
    );

    always #5 prog_clk = ~prog_clk;

    exp_t sbq[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // model state
    bit             m_sr[$];     // shifted bits, most recent first
    bit             m_act[CB];
    int             m_cnt;
    bit             m_valid, m_err;
    logic [0:4*W-1] m_reg;
    // values held across the upcoming edge
    bit             h_en, h_head, h_commit, h_rst;
    logic [0:W-1]   h_in[4];

    function automatic bit sr_bit(int j);
        return (j < m_sr.size()) ? m_sr[j] : 1'b0;
    endfunction

    // output track (s,i) carries nothing, or track i of the side that is
    // "select" steps clockwise from side s
    function automatic logic [0:4*W-1] route();
        logic [0:4*W-1] r;
        int m, sel;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < W; i++) begin
                m   = s * W + i;
                sel = 2 * int'(m_act[2*m]) + int'(m_act[2*m+1]);
                r[m] = (sel == 0) ? 1'b0 : h_in[(s + sel) % 4][i];
            end
        return r;
    endfunction

    task automatic model_clear();
        m_sr.delete();
        for (int j = 0; j < CB; j++) m_act[j] = 1'b0;
        m_cnt = 0; m_valid = 1'b0; m_err = 1'b0; m_reg = '0;
    endtask

    task automatic model_edge();
        logic [0:4*W-1] pre;
        pre = route();
        if (h_rst) begin
            model_clear();
            return;
        end
        m_reg = pre;
        if (h_commit) begin
            if (m_cnt == CB) begin
                for (int j = 0; j < CB; j++) m_act[j] = sr_bit(j);
                m_valid = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            m_cnt = h_en ? 1 : 0;
        end else if (h_en && m_cnt < CB + 1) begin
            m_cnt++;
        end
        if (h_en) begin
            m_sr.push_front(h_head);
            if (m_sr.size() > CB) void'(m_sr.pop_back());
        end
    endtask

    function automatic logic [0:W-1] rnd();
        return W'($urandom);
    endfunction

    // one clock of stimulus: settle the model for the edge just taken,
    // drive the next inputs, record the expected response
    task automatic cyc(input bit en, input bit head, input bit commit, input bit rst,
                       input logic [0:W-1] t, input logic [0:W-1] r,
                       input logic [0:W-1] b, input logic [0:W-1] l);
        exp_t e;
        @(posedge prog_clk);
        #2;
        model_edge();
        h_en = en; h_head = head; h_commit = commit; h_rst = rst;
        h_in[0] = t; h_in[1] = r; h_in[2] = b; h_in[3] = l;
        prog_reset            = rst;
        sb.ccff_en            = en;
        sb.ccff_head          = head;
        sb.ccff_commit        = commit;
        sb.chany_top_in       = t;
        sb.chanx_right_in     = r;
        sb.chany_bottom_in    = b;
        sb.chanx_left_in      = l;
        if (rst) model_clear();
`ifdef SB_OUT_REG_EN
        e.o = m_reg;
`else
        e.o = route();
`endif
        e.tail  = sr_bit(CB - 1);
        e.valid = m_valid;
        e.err   = m_err;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd(), rnd(), rnd(), rnd());
    endtask

    task automatic shift_rand(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0, rnd(), rnd(), rnd(), rnd());
    endtask

    task automatic commit_only();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd(), rnd(), rnd(), rnd());
    endtask

    // monitor: compare whatever the driver expected for this cycle
    initial begin
        exp_t           e;
        logic [0:4*W-1] a;
        bit             bad;
        forever begin
            @(negedge prog_clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int i = 0; i < W; i++) begin
                    a[i]       = sb.chany_top_out[i];
                    a[W+i]     = sb.chanx_right_out[i];
                    a[2*W+i]   = sb.chany_bottom_out[i];
                    a[3*W+i]   = sb.chanx_left_out[i];
                end
                bad = 1'b0;
                if (a !== e.o) begin
                    $display("FAIL tracks_out t=%0t got %h expected %h", $time, a, e.o); bad = 1'b1;
                end
                if (sb.ccff_tail !== e.tail) begin
                    $display("FAIL ccff_tail t=%0t got %b expected %b", $time, sb.ccff_tail, e.tail); bad = 1'b1;
                end
                if (sb.cfg_valid !== e.valid) begin
                    $display("FAIL cfg_valid t=%0t got %b expected %b", $time, sb.cfg_valid, e.valid); bad = 1'b1;
                end
                if (sb.cfg_err !== e.err) begin
                    $display("FAIL cfg_err t=%0t got %b expected %b", $time, sb.cfg_err, e.err); bad = 1'b1;
                end
                n_vec++;
                if (bad) n_miss++;
            end
        end
    end

    initial begin
        logic [1:CB] pat;
        // time-zero values, reset held from the start
        h_en = 0; h_head = 0; h_commit = 0; h_rst = 1;
        for (int s = 0; s < 4; s++) h_in[s] = '0;
        sb.ccff_en = 0; sb.ccff_head = 0; sb.ccff_commit = 0;
        sb.chany_top_in = '0; sb.chanx_right_in = '0;
        sb.chany_bottom_in = '0; sb.chanx_left_in = '0;
        model_clear();

        // reset with random inputs
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, rnd(), rnd(), rnd(), rnd());
        idle(2);

        // single route: top track 0 from bottom (select 10 on mux 0)
        pat = '0;
        pat[CB] = 1'b1;
        for (int k = 1; k <= CB; k++) cyc(1'b1, pat[k], 1'b0, 1'b0, rnd(), rnd(), rnd(), rnd());
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd(), rnd(), 4'b1000, rnd());
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd(), rnd(), 4'b1000, rnd());
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd(), rnd(), 4'b0000, rnd());
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd(), rnd(), 4'b1000, rnd());
        idle(2);

        // chain passthrough, no commit: routing must hold
        shift_rand(40);
        idle(2);

        // short load rejected, then a full load accepted
        shift_rand(CB - 1);
        commit_only();
        idle(2);
        shift_rand(CB);
        commit_only();
        idle(4);

        // commit on the same edge as a shift, then finish a load from count 1
        shift_rand(CB);
        cyc(1'b1, 1'($urandom), 1'b1, 1'b0, rnd(), rnd(), rnd(), rnd());
        shift_rand(CB - 1);
        commit_only();
        idle(4);

        // reset in the middle of a shift, then reprogram and toggle inputs
        shift_rand(10);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, rnd(), rnd(), rnd(), rnd());
        cyc(1'b1, 1'b1, 1'b0, 1'b1, rnd(), rnd(), rnd(), rnd());
        idle(1);
        shift_rand(CB);
        commit_only();
        idle(20);

        // randomized traffic: full loads interleaved with stray shifts and commits
        for (int r = 0; r < 10; r++) begin
            shift_rand(CB);
            commit_only();
            for (int k = 0; k < 25; k++)
                cyc(1'($urandom_range(0, 4) == 0), 1'($urandom),
                    1'($urandom_range(0, 30) == 0), 1'b0, rnd(), rnd(), rnd(), rnd());
        end
        for (int k = 0; k < 300; k++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom),
                1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 150) == 0),
                rnd(), rnd(), rnd(), rnd());
        idle(3);

        // let the monitor drain the scoreboard
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge prog_clk);
        @(posedge prog_clk);
        if (sbq.size() != 0) begin
            $display("FAIL scoreboard_drain got %0d pending expected 0", sbq.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
